// File: rtl/ghost_ai.sv
// ghost_ai : one Pac-Man ghost -- mode sequencing plus per-frame maze movement.
//
// Parameters
//   INITIAL_X / INITIAL_Y : home position, used at reset and as the EATEN target
//   MOVE_STEP             : pixels per move (doubled while EATEN)
//   TILES_AHEAD, TILE_W/H : chase look-ahead distance in front of Pac-Man
//   SCATTER_X / SCATTER_Y : scatter corner target
//   *_FRAMES              : duration of SCATTER, CHASE and FRIGHT in frames
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   frame_enable          : one-cycle pulse per video frame; moves, timer, LFSR
//   ghost_*_wall          : wall present in that direction from the ghost
//   BallX, BallY, keycode : Pac-Man position and heading
//   power_pellet          : pulse, frighten the ghost
//   ghost_eaten           : pulse, ghost caught while frightened
//   ghost_x, ghost_y      : ghost position
//   mode                  : 0 SCATTER, 1 CHASE, 2 FRIGHT, 3 EATEN
//   dir                   : last move, 0 up, 1 down, 2 left, 3 right
//   frightened            : registered copy of (mode == FRIGHT)

module ghost_ai #(
  parameter logic [9:0] INITIAL_X      = 10'd209,
  parameter logic [9:0] INITIAL_Y      = 10'd222,
  parameter int         MOVE_STEP      = 1,
  parameter int         TILES_AHEAD    = 4,
  parameter int         TILE_W         = 17,
  parameter int         TILE_H         = 15,
  parameter logic [9:0] SCATTER_X      = 10'd20,
  parameter logic [9:0] SCATTER_Y      = 10'd20,
  parameter int         SCATTER_FRAMES = 420,
  parameter int         CHASE_FRAMES   = 1200,
  parameter int         FRIGHT_FRAMES  = 360
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_enable,
  input  logic       ghost_up_wall,
  input  logic       ghost_down_wall,
  input  logic       ghost_left_wall,
  input  logic       ghost_right_wall,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  input  logic [7:0] keycode,
  input  logic       power_pellet,
  input  logic       ghost_eaten,
  output logic [9:0] ghost_x,
  output logic [9:0] ghost_y,
  output logic [1:0] mode,
  output logic [1:0] dir,
  output logic       frightened
);

  localparam logic [1:0] MODE_SCATTER = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_FRIGHT  = 2'd2;
  localparam logic [1:0] MODE_EATEN   = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [10:0] OFF_X = 11'(TILES_AHEAD * TILE_W);
  localparam logic [10:0] OFF_Y = 11'(TILES_AHEAD * TILE_H);

  localparam logic [15:0] T_SCATTER = 16'(SCATTER_FRAMES);
  localparam logic [15:0] T_CHASE   = 16'(CHASE_FRAMES);
  localparam logic [15:0] T_FRIGHT  = 16'(FRIGHT_FRAMES);

  logic [15:0] timer;
  logic [1:0]  saved_mode;
  logic [7:0]  lfsr;
  logic        fright_entry;

  logic [9:0]  target_x, target_y;
  logic [10:0] ball_x_plus, ball_y_plus;
  logic [9:0]  ball_x_minus, ball_y_minus;
  logic [9:0]  ball_x_sat, ball_y_sat;
  logic [10:0] dx, dy, adx, ady;
  logic [1:0]  h_toward, v_toward;
  logic [1:0]  cand [4];
  logic [3:0]  walls;
  logic [1:0]  rev_dir;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic [9:0]  step;
  logic [9:0]  next_x, next_y;

  logic [1:0]  mode_n, saved_n;
  logic [15:0] timer_n;
  logic        entry_n;

  // Walls indexed by direction code so a candidate direction can look itself up.
  assign walls   = {ghost_right_wall, ghost_left_wall, ghost_down_wall, ghost_up_wall};
  assign rev_dir = {dir[1], ~dir[0]};

  // Look-ahead point in front of Pac-Man, clamped to the 0..1023 screen range.
  assign ball_x_plus  = {1'b0, BallX} + OFF_X;
  assign ball_y_plus  = {1'b0, BallY} + OFF_Y;
  assign ball_x_sat   = ball_x_plus[10] ? 10'h3FF : ball_x_plus[9:0];
  assign ball_y_sat   = ball_y_plus[10] ? 10'h3FF : ball_y_plus[9:0];
  assign ball_x_minus = ({1'b0, BallX} >= OFF_X) ? 10'({1'b0, BallX} - OFF_X) : 10'd0;
  assign ball_y_minus = ({1'b0, BallY} >= OFF_Y) ? 10'({1'b0, BallY} - OFF_Y) : 10'd0;

  // Target point for the current mode; FRIGHT ignores it and steers randomly.
  always_comb begin
    target_x = BallX;
    target_y = BallY;
    case (mode)
      MODE_SCATTER: begin
        target_x = SCATTER_X;
        target_y = SCATTER_Y;
      end
      MODE_CHASE: begin
        case (keycode)
          8'h1A:   target_y = ball_y_minus;
          8'h16:   target_y = ball_y_sat;
          8'h04:   target_x = ball_x_minus;
          8'h07:   target_x = ball_x_sat;
          default: ;
        endcase
      end
      MODE_EATEN: begin
        target_x = INITIAL_X;
        target_y = INITIAL_Y;
      end
      default: ;
    endcase
  end

  // Signed 11-bit deltas; a zero delta counts as "toward" right/down.
  assign dx       = {1'b0, target_x} - {1'b0, ghost_x};
  assign dy       = {1'b0, target_y} - {1'b0, ghost_y};
  assign adx      = dx[10] ? -dx : dx;
  assign ady      = dy[10] ? -dy : dy;
  assign h_toward = dx[10] ? DIR_LEFT : DIR_RIGHT;
  assign v_toward = dy[10] ? DIR_UP : DIR_DOWN;

  // Candidate directions in preference order. Frightened ghosts rotate the
  // fixed up/down/left/right list by the LFSR instead of chasing a target.
  always_comb begin
    for (int i = 0; i < 4; i++) cand[i] = DIR_UP;
    if (mode == MODE_FRIGHT) begin
      for (int i = 0; i < 4; i++) cand[i] = 2'(i) + lfsr[1:0];
    end else if (adx > ady) begin
      cand[0] = h_toward;
      cand[1] = v_toward;
      cand[2] = {v_toward[1], ~v_toward[0]};
      cand[3] = {h_toward[1], ~h_toward[0]};
    end else begin
      cand[0] = v_toward;
      cand[1] = h_toward;
      cand[2] = {h_toward[1], ~h_toward[0]};
      cand[3] = {v_toward[1], ~v_toward[0]};
    end
  end

  // Pick the first open, non-reversing candidate; reversing is the fallback,
  // except right after being frightened where reversing is preferred.
  always_comb begin
    move_valid = 1'b0;
    move_dir   = dir;
    if (fright_entry && (mode == MODE_FRIGHT) && !walls[rev_dir]) begin
      move_valid = 1'b1;
      move_dir   = rev_dir;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!move_valid && !walls[cand[i]] && (cand[i] != rev_dir)) begin
          move_valid = 1'b1;
          move_dir   = cand[i];
        end
      end
      if (!move_valid && !walls[rev_dir]) begin
        move_valid = 1'b1;
        move_dir   = rev_dir;
      end
    end
  end

  // Position after this frame's move; 10-bit arithmetic wraps around the screen.
  assign step = (mode == MODE_EATEN) ? 10'(2 * MOVE_STEP) : 10'(MOVE_STEP);

  always_comb begin
    next_x = ghost_x;
    next_y = ghost_y;
    if (move_valid) begin
      case (move_dir)
        DIR_UP:    next_y = ghost_y - step;
        DIR_DOWN:  next_y = ghost_y + step;
        DIR_LEFT:  next_x = ghost_x - step;
        default:   next_x = ghost_x + step;
      endcase
    end
  end

  // Mode sequencing. Pellet/eaten pulses act on any edge and take priority
  // over the frame timer; eaten beats a simultaneous pellet in FRIGHT.
  always_comb begin
    mode_n  = mode;
    timer_n = timer;
    saved_n = saved_mode;
    entry_n = frame_enable ? 1'b0 : fright_entry;
    if ((mode == MODE_FRIGHT) && ghost_eaten) begin
      mode_n  = MODE_EATEN;
      entry_n = 1'b0;
    end else if (power_pellet && ((mode == MODE_SCATTER) || (mode == MODE_CHASE))) begin
      saved_n = mode;
      mode_n  = MODE_FRIGHT;
      timer_n = T_FRIGHT;
      entry_n = 1'b1;
    end else if (power_pellet && (mode == MODE_FRIGHT)) begin
      timer_n = T_FRIGHT;
    end else if (frame_enable) begin
      if (mode == MODE_EATEN) begin
        if ((next_x == INITIAL_X) && (next_y == INITIAL_Y)) begin
          mode_n  = MODE_SCATTER;
          timer_n = T_SCATTER;
        end
      end else if (timer <= 16'd1) begin
        case (mode)
          MODE_SCATTER: begin
            mode_n  = MODE_CHASE;
            timer_n = T_CHASE;
          end
          MODE_CHASE: begin
            mode_n  = MODE_SCATTER;
            timer_n = T_SCATTER;
          end
          default: begin
            mode_n  = saved_mode;
            timer_n = (saved_mode == MODE_CHASE) ? T_CHASE : T_SCATTER;
          end
        endcase
      end else begin
        timer_n = timer - 16'd1;
      end
    end
  end

  // State registers; movement and the LFSR advance only on frame pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghost_x      <= INITIAL_X;
      ghost_y      <= INITIAL_Y;
      mode         <= MODE_SCATTER;
      timer        <= T_SCATTER;
      saved_mode   <= MODE_SCATTER;
      dir          <= DIR_LEFT;
      lfsr         <= 8'hA5;
      frightened   <= 1'b0;
      fright_entry <= 1'b0;
    end else begin
      mode         <= mode_n;
      timer        <= timer_n;
      saved_mode   <= saved_n;
      fright_entry <= entry_n;
      frightened   <= (mode_n == MODE_FRIGHT);
      if (frame_enable) begin
        ghost_x <= next_x;
        ghost_y <= next_y;
        dir     <= move_dir;
        lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
    end
  end

endmodule

// File: tb/tb_ghost_ai.sv
// tb_ghost_ai : directed bench for ghost_ai -- mode timing, chase steering,
// wall handling, frightened entry and the eaten return-home path.

module tb_ghost_ai;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_enable = 1'b0;
  logic       ghost_up_wall = 1'b0;
  logic       ghost_down_wall = 1'b0;
  logic       ghost_left_wall = 1'b0;
  logic       ghost_right_wall = 1'b0;
  logic [9:0] BallX = 10'd0;
  logic [9:0] BallY = 10'd0;
  logic [7:0] keycode = 8'h00;
  logic       power_pellet = 1'b0;
  logic       ghost_eaten = 1'b0;
  logic [9:0] ghost_x, ghost_y;
  logic [1:0] mode, dir;
  logic       frightened;

  int checks = 0;
  int errors = 0;

  ghost_ai dut (
    .clk              (clk),
    .reset            (reset),
    .frame_enable     (frame_enable),
    .ghost_up_wall    (ghost_up_wall),
    .ghost_down_wall  (ghost_down_wall),
    .ghost_left_wall  (ghost_left_wall),
    .ghost_right_wall (ghost_right_wall),
    .BallX            (BallX),
    .BallY            (BallY),
    .keycode          (keycode),
    .power_pellet     (power_pellet),
    .ghost_eaten      (ghost_eaten),
    .ghost_x          (ghost_x),
    .ghost_y          (ghost_y),
    .mode             (mode),
    .dir              (dir),
    .frightened       (frightened)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Issue n frame pulses; returns on a falling edge after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(negedge clk);
      frame_enable = 1'b1;
      @(negedge clk);
      frame_enable = 1'b0;
    end
  endtask

  // One-cycle power_pellet / ghost_eaten pulse with no frame pulse.
  task automatic pulseEvents(input logic pp, input logic ge);
    @(negedge clk);
    power_pellet = pp;
    ghost_eaten  = ge;
    @(negedge clk);
    power_pellet = 1'b0;
    ghost_eaten  = 1'b0;
  endtask

  task automatic setWalls(input logic u, input logic d, input logic l, input logic r);
    ghost_up_wall    = u;
    ghost_down_wall  = d;
    ghost_left_wall  = l;
    ghost_right_wall = r;
  endtask

  // Reset pulse that lands between clock edges.
  task automatic doReset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Power-on reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_x", ghost_x, 10'd209);
    checkOutput("reset_y", ghost_y, 10'd222);
    checkOutput("reset_mode", 10'(mode), 10'd0);
    checkOutput("reset_dir", 10'(dir), 10'd2);
    checkOutput("reset_fright", 10'(frightened), 10'd0);
    reset = 1'b0;

    // Scatter/chase timing with open maze
    $display("[TB] scatter/chase timing");
    applyStimulus(419);
    checkOutput("scatter_419", 10'(mode), 10'd0);
    applyStimulus(1);
    checkOutput("chase_420", 10'(mode), 10'd1);
    applyStimulus(1199);
    checkOutput("chase_1619", 10'(mode), 10'd1);
    applyStimulus(1);
    checkOutput("scatter_1620", 10'(mode), 10'd0);

    // Asynchronous reset mid-run, observed before any clock edge
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_x", ghost_x, 10'd209);
    checkOutput("async_y", ghost_y, 10'd222);
    checkOutput("async_mode", 10'(mode), 10'd0);
    checkOutput("async_dir", 10'(dir), 10'd2);
    @(negedge clk);
    reset = 1'b0;

    // Fully walled: hold position and dir through scatter into chase
    $display("[TB] walled hold and wall avoidance");
    setWalls(1, 1, 1, 1);
    applyStimulus(420);
    checkOutput("hold_mode", 10'(mode), 10'd1);
    checkOutput("hold_x", ghost_x, 10'd209);
    checkOutput("hold_y", ghost_y, 10'd222);
    checkOutput("hold_dir", 10'(dir), 10'd2);

    // Target up-left, up and left walled, right is reversal -> down
    setWalls(1, 0, 1, 0);
    BallX = 10'd100;
    BallY = 10'd100;
    keycode = 8'h00;
    applyStimulus(1);
    checkOutput("avoid_dir", 10'(dir), 10'd1);
    checkOutput("avoid_y", ghost_y, 10'd223);
    checkOutput("avoid_x", ghost_x, 10'd209);

    // Three non-reverse directions walled -> forced reversal to right
    doReset();
    setWalls(1, 1, 1, 1);
    applyStimulus(420);
    setWalls(1, 1, 1, 0);
    BallX = 10'd300;
    BallY = 10'd222;
    keycode = 8'h07;
    applyStimulus(1);
    checkOutput("reverse_dir", 10'(dir), 10'd3);
    checkOutput("reverse_x", ghost_x, 10'd210);

    // Chase look-ahead to the right: one pixel per frame toward x=368
    $display("[TB] chase steering");
    setWalls(0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1);
      checkOutput("chase_x", ghost_x, 10'(210 + i));
    end
    checkOutput("chase_y", ghost_y, 10'd222);
    checkOutput("chase_dir", 10'(dir), 10'd3);

    // Power pellet in chase: frighten, reverse, then back to chase
    $display("[TB] frightened");
    pulseEvents(1'b1, 1'b0);
    checkOutput("fright_mode", 10'(mode), 10'd2);
    checkOutput("fright_flag", 10'(frightened), 10'd1);
    applyStimulus(1);
    checkOutput("fright_rev_dir", 10'(dir), 10'd2);
    checkOutput("fright_rev_x", ghost_x, 10'd212);
    applyStimulus(358);
    checkOutput("fright_359", 10'(mode), 10'd2);
    applyStimulus(1);
    checkOutput("fright_exit_mode", 10'(mode), 10'd1);
    checkOutput("fright_exit_flag", 10'(frightened), 10'd0);
    applyStimulus(1199);
    checkOutput("rechase_1199", 10'(mode), 10'd1);
    applyStimulus(1);
    checkOutput("rechase_1200", 10'(mode), 10'd0);

    // Eaten path: move to x=211, frighten, eat, run home at 2 px/frame
    $display("[TB] eaten");
    doReset();
    setWalls(1, 1, 1, 1);
    applyStimulus(420);
    setWalls(1, 1, 1, 0);
    applyStimulus(2);
    checkOutput("pre_eat_x", ghost_x, 10'd211);
    setWalls(1, 1, 1, 1);
    pulseEvents(1'b0, 1'b1);
    checkOutput("eaten_ignored", 10'(mode), 10'd1);
    pulseEvents(1'b1, 1'b0);
    checkOutput("pellet_mode", 10'(mode), 10'd2);
    pulseEvents(1'b1, 1'b1);
    checkOutput("eaten_mode", 10'(mode), 10'd3);
    checkOutput("eaten_flag", 10'(frightened), 10'd0);
    pulseEvents(1'b1, 1'b0);
    checkOutput("pellet_ignored", 10'(mode), 10'd3);
    setWalls(0, 0, 0, 0);
    applyStimulus(1);
    checkOutput("home1_x", ghost_x, 10'd211);
    checkOutput("home1_y", ghost_y, 10'd224);
    checkOutput("home1_dir", 10'(dir), 10'd1);
    checkOutput("home1_mode", 10'(mode), 10'd3);
    applyStimulus(1);
    checkOutput("home2_x", ghost_x, 10'd209);
    checkOutput("home2_y", ghost_y, 10'd224);
    checkOutput("home2_dir", 10'(dir), 10'd2);
    applyStimulus(1);
    checkOutput("home3_x", ghost_x, 10'd209);
    checkOutput("home3_y", ghost_y, 10'd222);
    checkOutput("home3_dir", 10'(dir), 10'd0);
    checkOutput("home3_mode", 10'(mode), 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
